interrupt_controller_mod: RTL and testbench
===========================================

INTERRUPT_CONTROLLER_MOD -- requirements
Module: interrupt_controller_mod

Interface
REQ-001 Parameter NUM_IRQ, default 5, number of interrupt sources (bit 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad).
REQ-002 Parameter VECTOR_BASE, default 16'h0040, dispatch address of source 0.
REQ-003 Parameter VECTOR_STRIDE, default 8, address spacing between consecutive source vectors.
REQ-004 Port list: clock in 1 system clock; reset in 1 async active-high reset.
REQ-005 irq_lines in 5: level request from each source; a 0->1 transition flags that source.
REQ-006 reg_wr in 1 register write strobe; reg_sel in 1 (0=IF at FF0F, 1=IE at FFFF); reg_wdata in 8 write data; reg_rdata out 8 read data of the selected register.
REQ-007 ime_set in 1 (EI retiring); ime_clear in 1 (DI retiring); reti in 1 (RETI retiring); inst_done in 1 (instruction boundary pulse from the control unit).
REQ-008 int_req out 1 dispatch request; int_vector out 16 dispatch target; int_ack in 1 one-cycle acceptance from the control unit.
REQ-009 halt_wake out 1 HALT exit request; ime out 1 current master-enable state.

Function
REQ-010 One clock; reset asynchronous, active-high; all state updates on posedge clock.
REQ-011 Edge detect: prev_lines register; IF bit n sets in the cycle after irq_lines[n] & ~prev_lines[n].
REQ-012 IF write: IF[4:0] <= reg_wdata[4:0]; a coincident edge on bit n forces IF[n]=1 (edge wins).
REQ-013 IE write: IE[7:0] <= reg_wdata; reads return IE unchanged.
REQ-014 IF reads return {3'b111, IF[4:0]}; reg_rdata is combinational from reg_sel.
REQ-015 pending = IE[4:0] & IF[4:0]; halt_wake = |pending, independent of ime and state, combinational.
REQ-016 Priority: lowest set pending index wins; int_vector = VECTOR_BASE + VECTOR_STRIDE*index (0x40,0x48,0x50,0x58,0x60); int_vector = VECTOR_BASE when nothing pending.
REQ-017 State machine IDLE, REQ, SERVICE.
REQ-018 IDLE->REQ when ime=1 and |pending; REQ->IDLE when pending clears or ime drops before int_ack; REQ->SERVICE on int_ack.
REQ-019 int_req = (state==REQ) & ime & |pending, combinational; deasserts in the same cycle its cause disappears.
REQ-020 On int_ack in REQ: latch winning index, clear that IF bit, clear ime, clear EI arming; other IF bits untouched.
REQ-021 A new edge on the acknowledged bit in the ack cycle re-sets that IF bit (edge wins over ack-clear).
REQ-022 SERVICE->IDLE on inst_done (dispatch microcode complete); int_req held 0 throughout SERVICE.
REQ-023 int_ack outside REQ is ignored: no IF, ime, or state change.
REQ-024 EI delay: ime_set arms ei_armed; ime becomes 1 in the cycle after the next inst_done following the arming cycle; inst_done coincident with ime_set does not count.
REQ-025 ime_clear: ime=0 next cycle and ei_armed cleared; coincident ime_set and ime_clear -> clear wins.
REQ-026 reti: ime=1 next cycle, no delay; reti coincident with ime_clear -> clear wins.
REQ-027 int_ack coincident with ime_clear: dispatch proceeds per REQ-020.

Reset
REQ-028 On reset: IF=5'b0 (reads 8'hE0), IE=8'h00, ime=0, ei_armed=0, state IDLE, prev_lines=5'b11111 (no spurious edge on release).
REQ-029 Outputs during reset: int_req=0, halt_wake=0, int_vector=16'h0040, ime=0.
REQ-030 Reset mid-SERVICE or mid-REQ aborts to IDLE with no IF update.

Structure
REQ-031 Shared package holds source bit indices, VECTOR_BASE/VECTOR_STRIDE defaults, IF/IE addresses, and the IDLE/REQ/SERVICE encoding.
REQ-032 One sub-module, irq_priority_encoder_mod: 5-bit pending in, valid and 3-bit index out, purely combinational.

Verification
REQ-033 IE=8'h1F, ime=1, edges on irq_lines[2] and [0] same cycle -> int_req=1, int_vector=16'h0040; int_ack -> IF=5'b00100, ime=0.
REQ-034 ime_set then two inst_done pulses, IE=8'h04, IF[2]=1 -> int_req stays 0 until the cycle after the second inst_done (EI delay).
REQ-035 ime=0, IE=8'h10, joypad edge -> halt_wake=1, int_req=0; reg_rdata with reg_sel=0 reads 8'hF0.
REQ-036 int_req pending on bit 3; IF write 8'h00 before int_ack -> int_req drops same cycle, state returns IDLE.
REQ-037 IF write 8'h00 coincident with edge on bit 1 -> IF reads 8'hE2.
REQ-038 Reset asserted in SERVICE -> IF, IE, ime cleared immediately; int_req=0; no edge flagged on release with lines high.

Source files
------------

// File: rtl/interrupt_controller_mod_pkg.sv
// Shared constants for the interrupt controller: source bit positions,
// vector layout defaults, register addresses and the dispatch FSM encoding.
package interrupt_controller_mod_pkg;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic [15:0] DEF_VECTOR_BASE   = 16'h0040;
  localparam int          DEF_VECTOR_STRIDE = 8;

  localparam logic [15:0] ADDR_IF = 16'hFF0F;
  localparam logic [15:0] ADDR_IE = 16'hFFFF;

  // reg_sel encoding of the two registers
  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_IE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/interrupt_controller_mod_prio.sv
// Fixed-priority encoder: the lowest set pending bit wins.
module irq_priority_encoder_mod #(
  parameter int W = 5
) (
  input  logic [W-1:0] pending_i,
  output logic         valid_o,
  output logic [2:0]   idx_o
);

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = 3'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/interrupt_controller_mod.sv
// Interrupt controller: edge-flagged IF, IE mask, delayed-EI master enable
// and a REQ/ack/SERVICE handshake with the control unit.
module interrupt_controller_mod
  import interrupt_controller_mod_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = DEF_VECTOR_BASE,
  parameter int          VECTOR_STRIDE = DEF_VECTOR_STRIDE
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] irq_lines_i,
  input  logic               reg_wr_i,
  input  logic               reg_sel_i,
  input  logic [7:0]         reg_wdata_i,
  output logic [7:0]         reg_rdata_o,
  input  logic               ime_set_i,
  input  logic               ime_clear_i,
  input  logic               reti_i,
  input  logic               inst_done_i,
  output logic               int_req_o,
  output logic [15:0]        int_vector_o,
  input  logic               int_ack_i,
  output logic               halt_wake_o,
  output logic               ime_o
);

  logic [NUM_IRQ-1:0] prev_q, if_q, if_d;
  logic [NUM_IRQ-1:0] edge_w, pending, ack_mask;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d, armed_q, armed_d;
  irq_state_e         state_q, state_d;
  logic [2:0]         win_idx, svc_idx_q, svc_idx_d, vec_idx;
  logic               win_vld, ack_fire;

  assign edge_w  = irq_lines_i & ~prev_q;
  assign pending = ie_q[NUM_IRQ-1:0] & if_q;

  irq_priority_encoder_mod #(.W(NUM_IRQ)) u_prio (
    .pending_i (pending),
    .valid_o   (win_vld),
    .idx_o     (win_idx)
  );

  assign int_req_o   = (state_q == ST_REQ) & ime_q & win_vld;
  assign ack_fire    = int_req_o & int_ack_i;
  assign halt_wake_o = |pending;
  assign ime_o       = ime_q;
  assign ack_mask    = NUM_IRQ'(1) << win_idx;

  // Once acknowledged the vector is held on the latched index, so the
  // dispatch microcode sees a stable target even after IF[idx] clears.
  assign vec_idx = (state_q == ST_SERVICE) ? svc_idx_q : win_idx;

  always_comb begin
    int_vector_o = VECTOR_BASE;
    if (state_q == ST_SERVICE || win_vld)
      int_vector_o = VECTOR_BASE + 16'(VECTOR_STRIDE) * {13'd0, vec_idx};
  end

  always_comb begin
    reg_rdata_o = 8'hFF;
    if (reg_sel_i == SEL_IE) reg_rdata_o = ie_q;
    else                     reg_rdata_o[NUM_IRQ-1:0] = if_q;
  end

  // Edges are OR-ed in last: a fresh edge beats both a write and an ack-clear.
  always_comb begin
    if_d = if_q;
    if (reg_wr_i && reg_sel_i == SEL_IF) if_d = reg_wdata_i[NUM_IRQ-1:0];
    if (ack_fire) if_d = if_d & ~ack_mask;
    if_d = if_d | edge_w;
  end

  always_comb begin
    ie_d = ie_q;
    if (reg_wr_i && reg_sel_i == SEL_IE) ie_d = reg_wdata_i;
  end

  // Later assignments win: clear and dispatch override every enable source.
  always_comb begin
    ime_d   = ime_q;
    armed_d = armed_q;
    if (armed_q && inst_done_i && !ime_set_i) begin
      ime_d   = 1'b1;
      armed_d = 1'b0;
    end
    if (ime_set_i) armed_d = 1'b1;
    if (reti_i)    ime_d   = 1'b1;
    if (ime_clear_i || ack_fire) begin
      ime_d   = 1'b0;
      armed_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    svc_idx_d = svc_idx_q;
    case (state_q)
      ST_IDLE:    if (ime_q && win_vld) state_d = ST_REQ;
      ST_REQ: begin
        if (ack_fire) begin
          state_d   = ST_SERVICE;
          svc_idx_d = win_idx;
        end else if (!int_req_o) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: if (inst_done_i) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // prev resets high so lines already asserted at release do not flag.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      prev_q    <= '1;
      if_q      <= '0;
      ie_q      <= 8'h00;
      ime_q     <= 1'b0;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      svc_idx_q <= 3'd0;
    end else begin
      prev_q    <= irq_lines_i;
      if_q      <= if_d;
      ie_q      <= ie_d;
      ime_q     <= ime_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      svc_idx_q <= svc_idx_d;
    end
  end

endmodule

// File: tb/tb_interrupt_controller_mod.sv
// Directed bench: register/priority table plus handshake and EI corner sequences.
module tb_interrupt_controller_mod;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_lines;
  logic        reg_wr, reg_sel, ime_set, ime_clear, reti, inst_done, int_ack;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        int_req, halt_wake, ime;
  logic [15:0] int_vector;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  interrupt_controller_mod dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .irq_lines_i  (irq_lines),
    .reg_wr_i     (reg_wr),
    .reg_sel_i    (reg_sel),
    .reg_wdata_i  (reg_wdata),
    .reg_rdata_o  (reg_rdata),
    .ime_set_i    (ime_set),
    .ime_clear_i  (ime_clear),
    .reti_i       (reti),
    .inst_done_i  (inst_done),
    .int_req_o    (int_req),
    .int_vector_o (int_vector),
    .int_ack_i    (int_ack),
    .halt_wake_o  (halt_wake),
    .ime_o        (ime)
  );

  typedef struct {
    logic [7:0]  ie;
    logic [7:0]  ifw;
    logic [15:0] vec;
    logic        halt;
    logic [7:0]  rd_if;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input logic sel, input logic [7:0] exp, input string name);
    reg_sel = sel;
    #1;
    chk(name, {24'd0, reg_rdata}, {24'd0, exp});
  endtask

  task automatic wr(input logic sel, input logic [7:0] data);
    reg_wr = 1'b1; reg_sel = sel; reg_wdata = data;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic pulse_reti();
    reti = 1'b1;
    step();
    reti = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_lines = 5'd0; reg_wr = 0; reg_sel = 0; reg_wdata = 0;
    ime_set = 0; ime_clear = 0; reti = 0; inst_done = 0; int_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'h1F, 8'h00, 16'h0040, 1'b0, 8'hE0};
    tbl[1] = '{8'h1F, 8'h1F, 16'h0040, 1'b1, 8'hFF};
    tbl[2] = '{8'h1F, 8'h1E, 16'h0048, 1'b1, 8'hFE};
    tbl[3] = '{8'h1F, 8'h1C, 16'h0050, 1'b1, 8'hFC};
    tbl[4] = '{8'h1F, 8'h18, 16'h0058, 1'b1, 8'hF8};
    tbl[5] = '{8'h1F, 8'h10, 16'h0060, 1'b1, 8'hF0};
    tbl[6] = '{8'h0C, 8'h13, 16'h0040, 1'b0, 8'hF3};
    tbl[7] = '{8'h0A, 8'h0E, 16'h0048, 1'b1, 8'hEE};
    tbl[8] = '{8'h14, 8'hFF, 16'h0050, 1'b1, 8'hFF};
    tbl[9] = '{8'hA0, 8'h1F, 16'h0040, 1'b0, 8'hFF};

    // Outputs while reset is held
    rst = 1'b1;
    irq_lines = 5'd0; reg_wr = 0; reg_sel = 0; reg_wdata = 0;
    ime_set = 0; ime_clear = 0; reti = 0; inst_done = 0; int_ack = 0;
    step();
    chk("rst_int_req", {31'd0, int_req}, 0);
    chk("rst_halt", {31'd0, halt_wake}, 0);
    chk("rst_vector", {16'd0, int_vector}, 32'h0040);
    chk("rst_ime", {31'd0, ime}, 0);
    chk_rd(1'b0, 8'hE0, "rst_if");
    chk_rd(1'b1, 8'h00, "rst_ie");

    // Table: register access and priority/vector mapping with ime=0
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr(1'b1, tbl[i].ie);
      wr(1'b0, tbl[i].ifw);
      chk($sformatf("tbl%0d_vec", i), {16'd0, int_vector}, {16'd0, tbl[i].vec});
      chk($sformatf("tbl%0d_halt", i), {31'd0, halt_wake}, {31'd0, tbl[i].halt});
      chk($sformatf("tbl%0d_req", i), {31'd0, int_req}, 0);
      chk_rd(1'b0, tbl[i].rd_if, $sformatf("tbl%0d_if", i));
      chk_rd(1'b1, tbl[i].ie, $sformatf("tbl%0d_ie", i));
    end

    // Simultaneous edges on 2 and 0, dispatch of source 0
    do_reset();
    wr(1'b1, 8'h1F);
    pulse_reti();
    chk("a_ime_reti", {31'd0, ime}, 1);
    irq_lines = 5'b00101;
    step();
    chk("a_req_idle", {31'd0, int_req}, 0);
    step();
    chk("a_req", {31'd0, int_req}, 1);
    chk("a_vec", {16'd0, int_vector}, 32'h0040);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk_rd(1'b0, 8'hE4, "a_if_after_ack");
    chk("a_ime_after_ack", {31'd0, ime}, 0);
    chk("a_req_service", {31'd0, int_req}, 0);
    chk("a_vec_service", {16'd0, int_vector}, 32'h0040);
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    chk("a_req_after_done", {31'd0, int_req}, 0);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk_rd(1'b0, 8'hE4, "a_stray_ack_if");
    chk("a_stray_ack_ime", {31'd0, ime}, 0);

    // EI delay: inst_done coincident with ime_set does not count
    do_reset();
    wr(1'b1, 8'h04);
    wr(1'b0, 8'h04);
    chk("b_halt", {31'd0, halt_wake}, 1);
    ime_set = 1'b1; inst_done = 1'b1;
    step();
    ime_set = 1'b0; inst_done = 1'b0;
    chk("b_ime0", {31'd0, ime}, 0);
    step();
    chk("b_ime1", {31'd0, ime}, 0);
    chk("b_req1", {31'd0, int_req}, 0);
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    chk("b_ime_on", {31'd0, ime}, 1);
    chk("b_req2", {31'd0, int_req}, 0);
    step();
    chk("b_req_on", {31'd0, int_req}, 1);
    chk("b_vec", {16'd0, int_vector}, 32'h0050);
    ime_clear = 1'b1;
    step();
    ime_clear = 1'b0;
    chk("b_req_drop", {31'd0, int_req}, 0);
    chk("b_ime_clr", {31'd0, ime}, 0);
    // Clear beats set, and arming is cancelled
    ime_set = 1'b1; ime_clear = 1'b1;
    step();
    ime_set = 1'b0; ime_clear = 1'b0;
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    step();
    chk("b_set_clr_ime", {31'd0, ime}, 0);
    reti = 1'b1; ime_clear = 1'b1;
    step();
    reti = 1'b0; ime_clear = 1'b0;
    chk("b_reti_clr_ime", {31'd0, ime}, 0);
    pulse_reti();
    chk("b_reti_ime", {31'd0, ime}, 1);

    // Wake without master enable
    do_reset();
    wr(1'b1, 8'h10);
    irq_lines = 5'b10000;
    step();
    chk("c_halt", {31'd0, halt_wake}, 1);
    chk("c_req", {31'd0, int_req}, 0);
    chk_rd(1'b0, 8'hF0, "c_if");

    // IF cleared by software while requesting
    do_reset();
    wr(1'b1, 8'h08);
    pulse_reti();
    irq_lines = 5'b01000;
    step();
    step();
    chk("d_req", {31'd0, int_req}, 1);
    chk("d_vec", {16'd0, int_vector}, 32'h0058);
    wr(1'b0, 8'h00);
    chk("d_req_drop", {31'd0, int_req}, 0);
    chk_rd(1'b0, 8'hE0, "d_if");
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("d_late_ack_ime", {31'd0, ime}, 1);

    // Edge wins over a coincident IF write
    do_reset();
    wr(1'b0, 8'h1C);
    chk_rd(1'b0, 8'hFC, "e_if_pre");
    irq_lines = 5'b00010;
    wr(1'b0, 8'h00);
    chk_rd(1'b0, 8'hE2, "e_if_edge_wins");

    // Edge on the acknowledged bit re-sets it; ime_clear in ack cycle
    do_reset();
    wr(1'b1, 8'h01);
    pulse_reti();
    irq_lines = 5'b00001;
    step();
    irq_lines = 5'b00000;
    step();
    chk("f_req", {31'd0, int_req}, 1);
    int_ack = 1'b1; ime_clear = 1'b1; irq_lines = 5'b00001;
    step();
    int_ack = 1'b0; ime_clear = 1'b0;
    chk_rd(1'b0, 8'hE1, "f_if_reset");
    chk("f_ime", {31'd0, ime}, 0);
    chk("f_req_service", {31'd0, int_req}, 0);

    // Reset while in SERVICE, lines held high across release
    do_reset();
    wr(1'b1, 8'h1F);
    pulse_reti();
    irq_lines = 5'b11111;
    step();
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk_rd(1'b0, 8'hFE, "g_if_service");
    rst = 1'b1;
    #1;
    chk("g_rst_req", {31'd0, int_req}, 0);
    chk("g_rst_ime", {31'd0, ime}, 0);
    chk("g_rst_halt", {31'd0, halt_wake}, 0);
    chk_rd(1'b0, 8'hE0, "g_rst_if");
    chk_rd(1'b1, 8'h00, "g_rst_ie");
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk_rd(1'b0, 8'hE0, "g_no_edge_if");
    chk("g_no_edge_halt", {31'd0, halt_wake}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
